// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating back-pressure counter.
module pipe_stage_skid #(
  parameter int unsigned        DATA_W    = 160,
  parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned        SKID      = 1,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              accept;
  logic              drain;

  // With a skid entry, ready depends only on state, cutting the path from dn_ready.
  always_comb begin
    if (SKID != 0) begin
      up_ready = ~s_valid_q;
    end else begin
      up_ready = ~m_valid_q | dn_ready;
    end
  end

  assign accept = up_valid & up_ready;
  assign drain  = m_valid_q & dn_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_data_d  = NOP_VALUE;
      s_data_d  = NOP_VALUE;
    end else if (SKID != 0) begin
      case ({m_valid_q, s_valid_q})
        2'b00: begin
          if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = up_data;
          end
        end
        2'b10: begin
          if (accept && drain) begin
            m_data_d = up_data;
          end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = up_data;
          end else if (drain) begin
            m_valid_d = 1'b0;
            m_data_d  = NOP_VALUE;
          end
        end
        2'b11: begin
          if (drain) begin
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
            s_data_d  = NOP_VALUE;
          end
        end
        default: begin
          // Unreachable (skid valid without main); recover to empty.
          m_valid_d = 1'b0;
          s_valid_d = 1'b0;
          m_data_d  = NOP_VALUE;
          s_data_d  = NOP_VALUE;
        end
      endcase
    end else begin
      if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = up_data;
      end else if (drain) begin
        m_valid_d = 1'b0;
        m_data_d  = NOP_VALUE;
      end
    end

    occ_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};

    stall_d = stall_q;
    if (m_valid_q && !dn_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= NOP_VALUE;
      s_data_q  <= NOP_VALUE;
      occ_q     <= 2'd0;
      stall_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
      occ_q     <= occ_d;
      stall_q   <= stall_d;
    end
  end

  assign dn_valid  = m_valid_q;
  assign dn_data   = m_data_q;
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid build, non-skid build and a 4-bit counter build
// share one stimulus bus; each test checks the instance it targets.
module tb_pipe_stage_skid;

  localparam int unsigned DW  = 16;
  localparam logic [DW-1:0] NOP = 16'hDEAD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          up_valid = 1'b0;
  logic [DW-1:0] up_data = '0;
  logic          dn_ready = 1'b0;

  logic          a_up_ready, a_dn_valid;
  logic [DW-1:0] a_dn_data;
  logic [1:0]    a_occ;
  logic [15:0]   a_stall;

  logic          b_up_ready, b_dn_valid;
  logic [DW-1:0] b_dn_data;
  logic [1:0]    b_occ;
  logic [15:0]   b_stall;

  logic          c_up_ready, c_dn_valid;
  logic [DW-1:0] c_dn_data;
  logic [1:0]    c_occ;
  logic [3:0]    c_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(a_up_ready),
    .up_data(up_data), .dn_valid(a_dn_valid), .dn_ready(dn_ready), .dn_data(a_dn_data),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_stage_skid #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(b_up_ready),
    .up_data(up_data), .dn_valid(b_dn_valid), .dn_ready(dn_ready), .dn_data(b_dn_data),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  pipe_stage_skid #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(c_up_ready),
    .up_data(up_data), .dn_valid(c_dn_valid), .dn_ready(dn_ready), .dn_data(c_dn_data),
    .occupancy(c_occ), .stall_cnt(c_stall)
  );

  typedef struct {
    logic          uv;
    logic [DW-1:0] ud;
    logic          dr;
    logic          fl;
    logic          ur;
    logic          dv;
    logic [DW-1:0] dd;
    logic [1:0]    occ;
    logic [15:0]   st;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic uv, input logic [DW-1:0] ud, input logic dr, input logic fl);
    up_valid = uv;
    up_data  = ud;
    dn_ready = dr;
    flush    = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // {uv, ud, dr, fl} -> post-edge {up_ready, dn_valid, dn_data, occupancy, stall_cnt}
    vecs[0]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 2'd1, 16'd0};
    vecs[1]  = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 2'd1, 16'd0};
    vecs[2]  = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 2'd1, 16'd0};
    vecs[3]  = '{1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0004, 2'd1, 16'd0};
    vecs[4]  = '{1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0005, 2'd1, 16'd0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, NOP,      2'd0, 16'd0};
    // Back-pressure: A, B fill both entries; C waits upstream.
    vecs[6]  = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000A, 2'd1, 16'd0};
    vecs[7]  = '{1'b1, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2, 16'd1};
    vecs[8]  = '{1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2, 16'd2};
    vecs[9]  = '{1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2, 16'd3};
    vecs[10] = '{1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000B, 2'd1, 16'd3};
    vecs[11] = '{1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000C, 2'd1, 16'd3};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, NOP,      2'd0, 16'd3};
    // Flush while holding two entries; 0x33 must never appear.
    vecs[13] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 2'd1, 16'd3};
    vecs[14] = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 2'd2, 16'd4};
    vecs[15] = '{1'b1, 16'h0033, 1'b0, 1'b1, 1'b1, 1'b0, NOP,      2'd0, 16'd5};
    vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, NOP,      2'd0, 16'd5};
    // Flush with a beat accepted in the same cycle: flush wins.
    vecs[17] = '{1'b1, 16'h0044, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0044, 2'd1, 16'd5};
    vecs[18] = '{1'b1, 16'h0055, 1'b0, 1'b1, 1'b1, 1'b0, NOP,      2'd0, 16'd6};
    vecs[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, NOP,      2'd0, 16'd6};

    // Reset state.
    do_reset();
    check("rst dn_valid", {31'd0, a_dn_valid}, 32'd0);
    check("rst dn_data", {16'd0, a_dn_data}, {16'd0, NOP});
    check("rst occupancy", {30'd0, a_occ}, 32'd0);
    check("rst stall_cnt", {16'd0, a_stall}, 32'd0);
    check("rst up_ready", {31'd0, a_up_ready}, 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].uv, vecs[i].ud, vecs[i].dr, vecs[i].fl);
      tick();
      check($sformatf("v%0d up_ready", i), {31'd0, a_up_ready}, {31'd0, vecs[i].ur});
      check($sformatf("v%0d dn_valid", i), {31'd0, a_dn_valid}, {31'd0, vecs[i].dv});
      check($sformatf("v%0d dn_data", i), {16'd0, a_dn_data}, {16'd0, vecs[i].dd});
      check($sformatf("v%0d occupancy", i), {30'd0, a_occ}, {30'd0, vecs[i].occ});
      check($sformatf("v%0d stall_cnt", i), {16'd0, a_stall}, {16'd0, vecs[i].st});
    end

    // Reset mid-operation with both entries held.
    drive(1'b1, 16'h0066, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0077, 1'b0, 1'b0);
    tick();
    check("pre-rst occupancy", {30'd0, a_occ}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst dn_valid", {31'd0, a_dn_valid}, 32'd0);
    check("midrst dn_data", {16'd0, a_dn_data}, {16'd0, NOP});
    check("midrst occupancy", {30'd0, a_occ}, 32'd0);
    check("midrst stall_cnt", {16'd0, a_stall}, 32'd0);
    check("midrst up_ready", {31'd0, a_up_ready}, 32'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check("postrst dn_valid", {31'd0, a_dn_valid}, 32'd0);

    // Non-skid build: upstream holds data until accepted; dn_ready toggles.
    do_reset();
    begin
      logic [DW-1:0] offer [7];
      logic          ready_pat [7];
      logic          exp_ur [7];
      logic [DW-1:0] exp_dd [7];
      offer     = '{16'h0001, 16'h0002, 16'h0002, 16'h0003, 16'h0003, 16'h0004, 16'h0000};
      ready_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_ur    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_dd    = '{16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'h0003, 16'h0003, NOP};
      for (int k = 0; k < 7; k++) begin
        drive((k < 6), offer[k], ready_pat[k], 1'b0);
        #1;
        check($sformatf("noskid c%0d up_ready", k), {31'd0, b_up_ready}, {31'd0, exp_ur[k]});
        tick();
        check($sformatf("noskid c%0d dn_data", k), {16'd0, b_dn_data}, {16'd0, exp_dd[k]});
        check($sformatf("noskid c%0d occupancy", k), {30'd0, b_occ}, (k < 6) ? 32'd1 : 32'd0);
      end
      check("noskid stall_cnt", {16'd0, b_stall}, 32'd3);
    end

    // Saturation on the 4-bit counter.
    do_reset();
    drive(1'b1, 16'h0009, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) check("sat stall 14", {28'd0, c_stall}, 32'd14);
      if (k == 15) check("sat stall 15", {28'd0, c_stall}, 32'd15);
    end
    check("sat stall hold", {28'd0, c_stall}, 32'd15);
    check("sat dn_data", {16'd0, c_dn_data}, 32'h0009);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic pipeline-stage register. It is the next generation of the fixed decode/execute stage latch.
- Replaces the global stall-vector scheme with a per-stage valid/ready handshake, an optional skid entry for full throughput with a registered ready, a synchronous flush for branch redirect, and a saturating back-pressure counter.
- Sits between any two pipeline stages (ID→EX first); the payload is an opaque bus.

Parameters:
- DATA_W, 160: payload width in bits (alusel, opcode, func3/7, operands, wd, wreg, link_addr, inst, branch_flag packed by the instantiator).
- NOP_VALUE, {DATA_W{1'b0}}: payload value driven when the stage is empty, after reset and after flush.
- SKID, 1: 1 gives a 2-entry stage with registered up_ready; 0 gives a 1-entry stage with combinational up_ready.
- CNT_W, 16: width of the stall counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- flush, input, 1: synchronous discard of all held entries.
- up_valid, input, 1: upstream offers a payload.
- up_ready, output, 1: stage accepts a payload this cycle.
- up_data, input, DATA_W: upstream payload.
- dn_valid, output, 1: stage presents a payload.
- dn_ready, input, 1: downstream consumes this cycle.
- dn_data, output, DATA_W: presented payload; equals NOP_VALUE when dn_valid=0.
- occupancy, output, 2: entries held (0..2; maximum 1 when SKID=0).
- stall_cnt, output, CNT_W: saturating count of cycles with dn_valid=1 and dn_ready=0.

Behaviour:
- Storage: main entry M (drives dn_*) and skid entry S (SKID=1 only). States are EMPTY (M and S invalid), ONE (M valid), TWO (M and S valid).
- Definitions: accept = up_valid & up_ready. drain = dn_valid & dn_ready.
- Reset, rst=1 (highest priority): M and S invalid, dn_valid=0, dn_data=NOP_VALUE, occupancy=0, stall_cnt=0. up_ready=1 in the cycle after reset when SKID=1.
- Flush, flush=1 (second priority): M and S invalidated, dn_data=NOP_VALUE next cycle. A beat accepted in the flush cycle is discarded. stall_cnt is not cleared.
- up_ready, SKID=1: registered, equal to !S.valid, so there is no combinational path from dn_ready.
- up_ready, SKID=0: equals !M.valid | dn_ready.
- Transitions, SKID=1:
  - EMPTY + accept → ONE, M=up_data.
  - ONE + accept & drain → ONE, M=up_data.
  - ONE + accept & !drain → TWO, S=up_data.
  - ONE + drain & !accept → EMPTY.
  - TWO + drain → ONE, M=S. No accept is possible in TWO because up_ready=0.
  - TWO + !drain → hold.
- Transitions, SKID=0: M loads up_data on accept; M is invalidated on drain without accept.
- Latency: 1 cycle from accept to dn_valid when the stage is empty. Throughput is 1 beat/cycle under continuous dn_ready.
- Ordering: strict FIFO order. No beat is duplicated or dropped except by flush.
- dn_data is registered and forced to NOP_VALUE whenever M is invalid, so a downstream that ignores dn_valid sees a bubble.
- occupancy is registered, equal to M.valid + S.valid.
- stall_cnt increments by 1 on each cycle with dn_valid & !dn_ready. It holds at all-ones and does not wrap.
- Simultaneous flush & accept: flush wins and the stage is empty next cycle.
- Simultaneous rst & flush: rst wins.
- Reset mid-transfer: all entries are lost and no partial payload is driven.

Test Plan:
- Continuous stream, SKID=1: up_valid=1 with data 1,2,3,4,5 on consecutive cycles, dn_ready=1 → dn_data 1..5 on the following 5 cycles, up_ready stays 1, occupancy=1, stall_cnt=0.
- Back-pressure: dn_ready=0 while data 0xA,0xB are offered → occupancy=2, up_ready=0, 0xC is held upstream. Raise dn_ready → dn_data sequence A,B,C with no loss, and stall_cnt equals the number of stalled cycles.
- Flush in TWO state: stage holds 0x11,0x22, assert flush with up_valid=1, data 0x33 → next cycle dn_valid=0, dn_data=NOP_VALUE, occupancy=0, and 0x33 is never emitted.
- SKID=0 build: dn_ready toggling 1,0,1,0 with continuous up_valid → up_ready mirrors dn_ready whenever the stage is full, output order is preserved, and occupancy never exceeds 1.
- Saturation, CNT_W=4: hold dn_valid=1, dn_ready=0 for 20 cycles → stall_cnt reads 15 and stays 15.
- Reset mid-operation: stage in TWO, assert rst for 1 cycle → dn_valid=0, dn_data=NOP_VALUE, occupancy=0, stall_cnt=0, and up_ready=1 in the following cycle.
